// File: rtl/uart_pkg.sv
// uart_pkg -- definitions shared by the UART receiver and transmitter.
//   DATA_BITS            : payload bits per frame
//   CLKS_PER_BIT_DEFAULT : default bit period in clock cycles
//   CNT_W                : width of the bit-period counter (covers 1..65535)
//   uart_state_e         : receiver FSM state encoding
package uart_pkg;

  localparam int DATA_BITS            = 8;
  localparam int CLKS_PER_BIT_DEFAULT = 1;
  localparam int CNT_W                = 16;
  localparam int IDX_W                = $clog2(DATA_BITS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/uart_sync2.sv
// uart_sync2 -- two-flop synchronizer for an asynchronous level input.
//   clk   : sampling clock
//   reset : synchronous active-high reset, flops go to 1 (idle line level)
//   d_i   : asynchronous input
//   q_o   : synchronized output, two cycles of latency
module uart_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] ff_q;

  always_ff @(posedge clk) begin
    if (reset) ff_q <= 2'b11;
    else       ff_q <= {ff_q[0], d_i};
  end

  assign q_o = ff_q[1];

endmodule

// File: rtl/uart_rx.sv
// uart_rx -- 8N1 UART receiver with a valid/ready output handshake.
//   clk       : clock, all state on rising edge
//   reset     : synchronous active-high reset
//   rx        : serial line (idle high), asynchronous to clk
//   rx_data   : received byte, stable while rx_valid is high
//   rx_valid  : rx_data holds an unconsumed byte
//   rx_ready  : consumer accepts the byte when rx_valid && rx_ready
//   busy      : receiver is inside a frame (FSM not idle)
//   frame_err : one-cycle pulse, stop bit sampled low (byte discarded)
//   overrun   : one-cycle pulse, completed byte dropped because the
//               previous one was still unconsumed
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 busy,
  output logic                 frame_err,
  output logic                 overrun
);

  // Start-bit detection is followed by HALF cycles of wait so every
  // subsequent sample lands near the middle of its bit period.
  localparam int             HALF       = (CLKS_PER_BIT - 1) / 2;
  localparam int             HALF_M1    = (HALF > 0) ? HALF - 1 : 0;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF   = CNT_W'(HALF_M1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DATA_BITS - 1);

  logic rx_s;

  uart_sync2 u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (rx),
    .q_o   (rx_s)
  );

  uart_state_e          state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;

  // Stop-bit outcome strobes, valid only in the stop-sample cycle.
  logic stop_ok, stop_bad;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

  // Next-state logic: frame sequencing, independent of rx_ready.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    stop_ok   = 1'b0;
    stop_bad  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          // With HALF=0 the detection cycle itself is the start-bit sample.
          if (HALF == 0) begin
            state_d   = ST_DATA;
            cnt_d     = CNT_RELOAD;
            bit_idx_d = '0;
          end else begin
            state_d   = ST_START;
            cnt_d     = CNT_HALF;
          end
        end
      end
      ST_START: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (!rx_s) begin
          state_d   = ST_DATA;
          cnt_d     = CNT_RELOAD;
          bit_idx_d = '0;
        end else begin
          // Line went back high by mid-start-bit: treat as a glitch.
          state_d = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          shreg_d[bit_idx_q] = rx_s;
          cnt_d              = CNT_RELOAD;
          if (bit_idx_q == IDX_LAST) state_d = ST_STOP;
          else                       bit_idx_d = bit_idx_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d  = ST_IDLE;
          stop_ok  = rx_s;
          stop_bad = !rx_s;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic: delivery into the holding register and status pulses.
  always_comb begin
    busy    = (state_q != ST_IDLE);
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = stop_bad;
    ovr_d   = 1'b0;
    if (valid_q && rx_ready) valid_d = 1'b0;
    if (stop_ok) begin
      // A byte being accepted this cycle frees the slot for the new one.
      if (!valid_q || rx_ready) begin
        data_d  = shreg_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx -- directed and randomized checks of uart_rx at CLKS_PER_BIT=1
// and CLKS_PER_BIT=16. Frames are driven serially from the bench and the
// expected delivery cycle is computed from the bit-timing rule:
// start bit driven after edge n -> rx_valid seen after edge n+3+HALF+9*CPB.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx1 = 1'b1, rx16 = 1'b1;
  logic       rdy1 = 1'b1, rdy16 = 1'b1;
  logic [7:0] d1, d16;
  logic       v1, v16, b1, b16, fe1, fe16, ov1, ov16;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx #(.CLKS_PER_BIT(1)) u_dut1 (
    .clk(clk), .reset(reset), .rx(rx1), .rx_data(d1), .rx_valid(v1),
    .rx_ready(rdy1), .busy(b1), .frame_err(fe1), .overrun(ov1)
  );

  uart_rx #(.CLKS_PER_BIT(16)) u_dut16 (
    .clk(clk), .reset(reset), .rx(rx16), .rx_data(d16), .rx_valid(v16),
    .rx_ready(rdy16), .busy(b16), .frame_err(fe16), .overrun(ov16)
  );

  // Monitor: log each new delivery (rising rx_valid) and every status pulse.
  logic         v1_prev = 1'b0, v16_prev = 1'b0;
  byte unsigned q16_data[$];
  int           q16_cyc[$];
  int           fe16_cyc[$];
  int           ov16_cyc[$];
  byte unsigned q1_data[$];
  int           q1_cyc[$];
  int           v1_hi = 0, fe1_n = 0;

  always @(negedge clk) begin
    if (v16 && !v16_prev) begin
      q16_data.push_back(d16);
      q16_cyc.push_back(cyc);
    end
    if (fe16) fe16_cyc.push_back(cyc);
    if (ov16) ov16_cyc.push_back(cyc);
    v16_prev <= v16;
    if (v1 && !v1_prev) begin
      q1_data.push_back(d1);
      q1_cyc.push_back(cyc);
    end
    if (v1)  v1_hi <= v1_hi + 1;
    if (fe1) fe1_n <= fe1_n + 1;
    v1_prev <= v1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_cyc(input int n, input int cpb);
    return n + 3 + (cpb - 1) / 2 + 9 * cpb;
  endfunction

  // Drive the first nbits of a frame; call just after a rising edge.
  task automatic send(input bit on16, input logic [7:0] b, input logic stop,
                      input int nbits, output int n);
    logic [9:0] fr;
    int cpb;
    fr  = {stop, b, 1'b0};
    cpb = on16 ? 16 : 1;
    n   = cyc;
    for (int k = 0; k < nbits; k++) begin
      if (on16) rx16 = fr[k];
      else      rx1  = fr[k];
      repeat (cpb) @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int c);
    repeat (c) @(posedge clk);
    #1;
  endtask

  initial begin
    int n0, n1, n2, base, fbase, obase, e;
    byte unsigned exp_b[$];
    int           exp_c[$];
    logic [7:0]   rb;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_out16", {d16, v16, b16, fe16, ov16}, 12'h000);
    chk("reset_out1",  {d1, v1, b1, fe1, ov1},      12'h000);
    @(posedge clk); #1;
    reset = 1'b0;
    idle(2);

    // CPB=1 single frame
    send(1'b0, 8'hA5, 1'b1, 10, n0);
    idle(5);
    chk("cpb1_count", q1_data.size(), 1);
    chk("cpb1_data",  q1_data[0], 8'hA5);
    chk("cpb1_cycle", q1_cyc[0], exp_cyc(n0, 1));
    chk("cpb1_vwidth", v1_hi, 1);
    chk("cpb1_ferr",  fe1_n, 0);

    // CPB=16 back-to-back frames
    base = q16_data.size();
    send(1'b1, 8'h00, 1'b1, 10, n0);
    send(1'b1, 8'hFF, 1'b1, 10, n1);
    send(1'b1, 8'h3C, 1'b1, 10, n2);
    idle(20);
    chk("b2b_count", q16_data.size() - base, 3);
    chk("b2b_d0", q16_data[base],   8'h00);
    chk("b2b_c0", q16_cyc[base],    exp_cyc(n0, 16));
    chk("b2b_d1", q16_data[base+1], 8'hFF);
    chk("b2b_c1", q16_cyc[base+1],  exp_cyc(n1, 16));
    chk("b2b_d2", q16_data[base+2], 8'h3C);
    chk("b2b_c2", q16_cyc[base+2],  exp_cyc(n2, 16));

    // Stop bit low: frame error, no delivery; next good frame delivered
    base = q16_data.size();
    send(1'b1, 8'h55, 1'b0, 9, n0);
    rx16 = 1'b0;
    idle(10);
    rx16 = 1'b1;
    idle(30);
    chk("ferr_count", fe16_cyc.size(), 1);
    chk("ferr_cycle", fe16_cyc[0], exp_cyc(n0, 16));
    chk("ferr_nodeliv", q16_data.size() - base, 0);
    chk("ferr_valid", v16, 1'b0);
    chk("ferr_busy",  b16, 1'b0);
    send(1'b1, 8'h12, 1'b1, 10, n1);
    idle(20);
    chk("after_ferr_count", q16_data.size() - base, 1);
    chk("after_ferr_data",  q16_data[base], 8'h12);
    chk("after_ferr_cycle", q16_cyc[base], exp_cyc(n1, 16));

    // 4-cycle glitch on an idle line
    base  = q16_data.size();
    fbase = fe16_cyc.size();
    rx16 = 1'b0;
    idle(4);
    rx16 = 1'b1;
    @(negedge clk);
    chk("glitch_busy_hi", b16, 1'b1);
    idle(20);
    chk("glitch_busy_lo", b16, 1'b0);
    chk("glitch_nodeliv", q16_data.size() - base, 0);
    chk("glitch_noferr",  fe16_cyc.size() - fbase, 0);

    // Overrun with consumer stalled
    base  = q16_data.size();
    obase = ov16_cyc.size();
    rdy16 = 1'b0;
    send(1'b1, 8'h11, 1'b1, 10, n0);
    send(1'b1, 8'h22, 1'b1, 10, n1);
    idle(10);
    chk("ovr_deliv",  q16_data.size() - base, 1);
    chk("ovr_held",   d16, 8'h11);
    chk("ovr_valid",  v16, 1'b1);
    chk("ovr_count",  ov16_cyc.size() - obase, 1);
    chk("ovr_cycle",  ov16_cyc[obase], exp_cyc(n1, 16));
    rdy16 = 1'b1;
    @(negedge clk);
    chk("hs_valid_still", v16, 1'b1);
    @(negedge clk);
    chk("hs_valid_clr", v16, 1'b0);

    // Reset in the middle of data bit 4 while a byte is pending
    @(posedge clk); #1;
    rdy16 = 1'b0;
    send(1'b1, 8'h77, 1'b1, 10, n0);
    idle(5);
    chk("pre_rst_data", {v16, d16}, 9'h177);
    base = q16_data.size();
    send(1'b1, 8'hF0, 1'b1, 5, n1);
    rx16 = 1'b1;
    idle(8);
    chk("mid_busy", b16, 1'b1);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("mid_rst_out", {d16, v16, b16, fe16, ov16}, 12'h000);
    @(posedge clk); #1;
    reset = 1'b0;
    rdy16 = 1'b1;
    idle(20);
    chk("post_rst_busy", b16, 1'b0);
    chk("post_rst_nodeliv", q16_data.size() - base, 0);
    send(1'b1, 8'h5A, 1'b1, 10, n2);
    idle(20);
    chk("post_rst_count", q16_data.size() - base, 1);
    chk("post_rst_data",  q16_data[base], 8'h5A);
    chk("post_rst_cycle", q16_cyc[base], exp_cyc(n2, 16));

    // Delivery coinciding with a handshake: new byte replaces old, valid stays
    obase = ov16_cyc.size();
    rdy16 = 1'b0;
    send(1'b1, 8'h81, 1'b1, 10, n0);
    n1 = n0 + 160;
    e  = exp_cyc(n1, 16);
    fork
      send(1'b1, 8'h7E, 1'b1, 10, n2);
      begin
        while (cyc < e - 1) begin
          @(posedge clk);
          #1;
        end
        rdy16 = 1'b1;
        @(negedge clk);
        chk("same_old", {v16, d16}, 9'h181);
        @(negedge clk);
        chk("same_new", {v16, d16}, 9'h17E);
        @(negedge clk);
        chk("same_clr", v16, 1'b0);
      end
    join
    idle(5);
    chk("same_noovr", ov16_cyc.size() - obase, 0);

    // Random bytes with random idle gaps
    base = q16_data.size();
    for (int i = 0; i < 6; i++) begin
      idle($urandom_range(0, 20));
      rb = 8'($urandom);
      send(1'b1, rb, 1'b1, 10, n0);
      exp_b.push_back(rb);
      exp_c.push_back(exp_cyc(n0, 16));
    end
    idle(20);
    chk("rand_count", q16_data.size() - base, exp_b.size());
    for (int i = 0; i < exp_b.size(); i++) begin
      chk($sformatf("rand_d%0d", i), q16_data[base+i], exp_b[i]);
      chk($sformatf("rand_c%0d", i), q16_cyc[base+i],  exp_c[i]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
